bcd_converter_11: RTL and testbench

- Converts an 11-bit unsigned binary value (0..2047) into a 4-digit packed BCD word (0000..2047).
- Registered double-dabble (shift-add-3) datapath: a combinational conversion followed by one output register stage.
- Feeds display/readout logic (e.g. 7-segment decoders) that needs decimal digits.
- Operates in a single clock domain with a synchronous, active-high reset.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_add3.sv | 24 ++
 rtl/bcd_converter_11.sv | 75 +++++++
 tb/tb_bcd_converter_11.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared widths and types for the 11-bit binary to 4-digit BCD converter.
//   BIN_W      : width of the binary operand (0..2047)
//   BCD_DIGITS : number of decimal digits produced
//   BCD_W      : packed BCD result width
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BIN_W      = 11;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef logic [3:0] bcd_digit_t;

    // [3] thousands, [2] hundreds, [1] tens, [0] ones
    typedef bcd_digit_t [BCD_DIGITS-1:0] bcd4_t;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//   Double-dabble correction cell for a single BCD digit. A digit of 5 or more
//   gets 3 added so that the following left shift carries correctly into the
//   next decimal digit.
//   Ports:
//     digit_i : current 4-bit digit value
//     digit_o : corrected digit (digit_i + 3 when digit_i >= 5, else digit_i)
// -----------------------------------------------------------------------------
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule : bcd_add3

// File: rtl/bcd_converter_11.sv
// -----------------------------------------------------------------------------
// bcd_converter_11
//   Converts an 11-bit unsigned value into a 4-digit packed BCD word using a
//   fully unrolled shift-add-3 array followed by a single output register.
//   Latency is one cycle, throughput one conversion per cycle.
//   Ports:
//     clk       : rising-edge clock
//     rst       : synchronous reset, active-high
//     A         : binary operand, sampled when in_valid=1
//     in_valid  : qualifies A
//     output11b : packed BCD {thousands, hundreds, tens, ones}; held while idle
//     out_valid : one-cycle pulse per accepted input, aligned with output11b
// -----------------------------------------------------------------------------
module bcd_converter_11
    import bcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  A,
    input  logic              in_valid,
    output logic [BCD_W-1:0]  output11b,
    output logic              out_valid
);

    // stage[i] is the accumulator after i input bits have been shifted in.
    bcd4_t stage [BIN_W+1];

    assign stage[0] = '0;

    genvar gi, gd;
    generate
        for (gi = 0; gi < BIN_W; gi++) begin : g_iter
            bcd4_t corr;

            // Correct every digit, then shift in the next bit (MSB first).
            // The first correction sees an all-zero accumulator and is a no-op;
            // keeping it makes every row identical.
            for (gd = 0; gd < BCD_DIGITS; gd++) begin : g_digit
                bcd_add3 u_add3 (
                    .digit_i (stage[gi][gd]),
                    .digit_o (corr[gd])
                );
            end

            // Bit 15 shifted out is always zero: the largest value, 2047,
            // only reaches 16'h2047 after the final shift.
            assign stage[gi+1] = (corr << 1) | BCD_W'(A[BIN_W-1-gi]);
        end
    endgenerate

    logic [BCD_W-1:0] bcd_d, bcd_q;
    logic             vld_d, vld_q;

    always_comb begin
        bcd_d = bcd_q;
        vld_d = in_valid;
        if (in_valid) begin
            bcd_d = stage[BIN_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q <= '0;
            vld_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            vld_q <= vld_d;
        end
    end

    assign output11b = bcd_q;
    assign out_valid = vld_q;

endmodule : bcd_converter_11

// File: tb/tb_bcd_converter_11.sv
module tb_bcd_converter_11;

    logic        clk;
    logic        rst;
    logic [10:0] A;
    logic        in_valid;
    logic [15:0] output11b;
    logic        out_valid;

    bcd_converter_11 dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .in_valid  (in_valid),
        .output11b (output11b),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bcd;
        logic        vld;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] model_bcd = 16'h0000;

    // Reference: plain decimal digit split of the operand.
    function automatic logic [15:0] dec_split(input int a);
        return {4'(a / 1000), 4'((a / 100) % 10), 4'((a / 10) % 10), 4'(a % 10)};
    endfunction

    // Drive one cycle from a falling edge, record the expected register
    // contents, then return at the next falling edge for sampling.
    task automatic drive(input logic r, input logic v, input int a);
        exp_t x;
        rst      = r;
        in_valid = v;
        A        = 11'(a);
        if (r) begin
            model_bcd = 16'h0000;
            x = '{bcd: 16'h0000, vld: 1'b0};
        end else if (v) begin
            model_bcd = dec_split(a);
            x = '{bcd: model_bcd, vld: 1'b1};
        end else begin
            x = '{bcd: model_bcd, vld: 1'b0};
        end
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 2047);
            e = sb.pop_front();
            n_cmp++;
            if (output11b !== e.bcd || out_valid !== e.vld) begin
                n_fail++;
                $display("FAIL reset[%0d]: got bcd=%h vld=%b, want bcd=%h vld=%b",
                         i, output11b, out_valid, e.bcd, e.vld);
            end
        end
    endtask

    task automatic test_boundaries();
        int vals [9] = '{0, 9, 10, 99, 100, 999, 1000, 2047, 1234};
        foreach (vals[i]) begin
            drive(1'b0, 1'b1, vals[i]);
            e = sb.pop_front();
            n_cmp++;
            if (output11b !== e.bcd || out_valid !== e.vld) begin
                n_fail++;
                $display("FAIL boundary A=%0d: got bcd=%h vld=%b, want bcd=%h vld=%b",
                         vals[i], output11b, out_valid, e.bcd, e.vld);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 2048; a++) begin
            drive(1'b0, 1'b1, a);
            e = sb.pop_front();
            n_cmp++;
            if (output11b !== e.bcd || out_valid !== e.vld ||
                output11b[15:12] > 4'd9 || output11b[11:8] > 4'd9 ||
                output11b[7:4] > 4'd9 || output11b[3:0] > 4'd9) begin
                n_fail++;
                $display("FAIL sweep A=%0d: got bcd=%h vld=%b, want bcd=%h vld=%b",
                         a, output11b, out_valid, e.bcd, e.vld);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 512);
        e = sb.pop_front();
        n_cmp++;
        if (output11b !== e.bcd || out_valid !== e.vld) begin
            n_fail++;
            $display("FAIL hold_load: got bcd=%h vld=%b, want bcd=%h vld=%b",
                     output11b, out_valid, e.bcd, e.vld);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 7);
            e = sb.pop_front();
            n_cmp++;
            if (output11b !== 16'h0512 || output11b !== e.bcd || out_valid !== e.vld) begin
                n_fail++;
                $display("FAIL hold_idle[%0d]: got bcd=%h vld=%b, want bcd=%h vld=%b",
                         i, output11b, out_valid, e.bcd, e.vld);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int  a_seq [3] = '{100, 200, 300};
        logic r_seq [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(r_seq[i], 1'b1, a_seq[i]);
            e = sb.pop_front();
            n_cmp++;
            if (output11b !== e.bcd || out_valid !== e.vld) begin
                n_fail++;
                $display("FAIL reset_mid[%0d] A=%0d rst=%b: got bcd=%h vld=%b, want bcd=%h vld=%b",
                         i, a_seq[i], r_seq[i], output11b, out_valid, e.bcd, e.vld);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        @(negedge clk);
        test_reset();
        test_boundaries();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_bcd_converter_11
